// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor: computes a - b - bin one bit per clock,
//   LSB first, and reports the WIDTH-bit difference plus final borrow.
//
// Ports
//   clk    : single clock, rising-edge active
//   rst_n  : asynchronous active-low reset
//   start  : request to begin a subtraction (sampled only in IDLE)
//   a, b   : minuend / subtrahend (WIDTH bits, sampled at the accepting edge)
//   bin    : borrow-in (sampled at the accepting edge)
//   busy   : high while an operation is running or its result is being flagged
//   done   : one-cycle pulse, diff/bout valid
//   diff   : a - b - bin modulo 2^WIDTH, held until the next completion
//   bout   : borrow-out, 1 iff a < b + bin
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d_bit;
  logic             br_next;

  // Operands are shifted right each RUN edge, so bit i of the original
  // operand is always at position 0 when the counter equals i.
  always_comb begin
    d_bit   = a_sh[0] ^ b_sh[0] ^ br;
    br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      d_sh  <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            d_sh  <= '0;
            br    <= bin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          // Difference bits enter at the MSB so after WIDTH edges bit 0
          // has reached position 0.
          d_sh <= {d_bit, d_sh[WIDTH-1:1]};
          br   <= br_next;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= {d_bit, d_sh[WIDTH-1:1]};
            bout  <= br_next;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and difference width in bits (WIDTH >= 2).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-004 The block SHALL have port start, input, 1 bit, request to begin a subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits, minuend.
REQ-006 The block SHALL have port b, input, WIDTH bits, subtrahend.
REQ-007 The block SHALL have port bin, input, 1 bit, borrow-in.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a subtraction is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, one-cycle result-valid pulse.
REQ-010 The block SHALL have port diff, output, WIDTH bits, result a - b - bin modulo 2^WIDTH.
REQ-011 The block SHALL have port bout, output, 1 bit, borrow-out; 1 iff a < b + bin (unsigned).

Function
REQ-012 The block SHALL implement an FSM with states IDLE, RUN and DONE, all outputs registered.
REQ-013 In IDLE, start=1 at a rising edge SHALL latch a, b and bin into internal working registers, clear the bit counter to 0 and move to RUN; otherwise the FSM stays in IDLE.
REQ-014 In RUN, each rising edge SHALL process exactly one bit i (LSB first, i = counter): d_i = a_i XOR b_i XOR br; br_next = (NOT a_i AND b_i) OR (NOT(a_i XOR b_i) AND br); the counter then increments.
REQ-015 The RUN state SHALL last exactly WIDTH rising edges; the edge that processes bit WIDTH-1 SHALL load diff with the full assembled difference, load bout with the final borrow, and move to DONE.
REQ-016 In DONE, done SHALL be 1 for exactly that one cycle; the next edge SHALL return the FSM to IDLE unconditionally.
REQ-017 Latency: with start accepted at edge k, done SHALL be high in the cycle after edge k+WIDTH (WIDTH+1 edges start-to-done).
REQ-018 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-019 diff and bout SHALL change only on the RUN->DONE edge and SHALL hold their values through IDLE until the next completion.
REQ-020 start SHALL be ignored in RUN and DONE; inputs a, b, bin SHALL be don't-care except at the accepting edge.
REQ-021 Back-to-back: start held high continuously SHALL begin a new operation at the first edge in IDLE after DONE, giving one result every WIDTH+2 cycles.
REQ-022 Width rule: the operation SHALL equal the (WIDTH+1)-bit two's-complement subtraction {0,a} - {0,b} - bin, with diff its low WIDTH bits and bout its sign bit.

Reset
REQ-023 rst_n=0 SHALL asynchronously force the FSM to IDLE, counter to 0, working registers to 0, busy=0, done=0, diff=0, bout=0.
REQ-024 Reset asserted mid-RUN SHALL abort the operation with no done pulse, and diff/bout SHALL read 0 afterwards.
REQ-025 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-026 WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse -> done after 9 edges, diff=0x1E, bout=0.
REQ-027 a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1; a=0x10, b=0x0F, bin=1 -> diff=0x00, bout=0.
REQ-028 a=0x00, b=0xFF, bin=1 -> diff=0x00, bout=1; a=0xFF, b=0x00, bin=0 -> diff=0xFF, bout=0.
REQ-029 Second start with different operands pulsed during RUN -> ignored; result matches the first operands; diff stable until its done.
REQ-030 rst_n pulsed low at the 4th RUN cycle -> busy=0, done never pulses, diff=0x00, bout=0; a new start then completes correctly.
REQ-031 Random self-check: 1000 random a, b, bin with start held high -> every done matches a - b - bin, with done spaced exactly 10 cycles apart.
